serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 30 +++
 rtl/serial_subtractor_chunk_sub.sv | 29 ++
 rtl/serial_subtractor.sv | 152 +++++++++++++++
 tb/tb_serial_subtractor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Purpose: shared types and sizing helpers for the serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_e     - controller states IDLE / RUN / DONE
//   num_chunks  - number of CHUNK_W slices needed to cover a (d_width+1)-bit sum
//   pad_w       - padded operand width (num_chunks * chunk_w)
package serial_subtractor_pkg;

  // Explicit encodings keep the state register layout stable for anything that
  // probes it by value.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil((d_width+1)/chunk_w): the sum is one bit wider than the addends.
  function automatic int num_chunks(input int d_width, input int chunk_w);
    return (d_width + chunk_w) / chunk_w;
  endfunction

  // Operands are zero-extended to a whole number of chunks so the shift
  // registers never need a ragged final slice.
  function automatic int pad_w(input int d_width, input int chunk_w);
    return num_chunks(d_width, chunk_w) * chunk_w;
  endfunction

endpackage

// File: rtl/serial_subtractor_chunk_sub.sv
// Purpose: one CHUNK_W-bit slice of a ripple-borrow subtractor, d = x - y - bin.
// Latency: purely combinational.
// Backpressure: none; the caller sequences the slices.
//
// Ports:
//   x    [CHUNK_W-1:0]  minuend slice
//   y    [CHUNK_W-1:0]  subtrahend slice
//   bin                 borrow in from the next-lower slice
//   d    [CHUNK_W-1:0]  difference slice
//   bout                borrow out to the next-higher slice
module chunk_sub #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] x,
  input  logic [CHUNK_W-1:0] y,
  input  logic               bin,
  output logic [CHUNK_W-1:0] d,
  output logic               bout
);

  // One guard bit on top: it goes to 1 exactly when x < y + bin, which is the
  // borrow we have to hand to the next slice.
  logic [CHUNK_W:0] diff;

  assign diff = {1'b0, x} - {1'b0, y} - {{CHUNK_W{1'b0}}, bin};
  assign d    = diff[CHUNK_W-1:0];
  assign bout = diff[CHUNK_W];

endmodule

// File: rtl/serial_subtractor.sv
// Purpose: recover b = c - a one CHUNK_W slice per clock, flagging results that need more than D_WIDTH bits.
// Latency: out_valid rises NUM_CHUNKS edges after the accepting edge; issue interval is NUM_CHUNKS+2.
// Backpressure: in_ready only in IDLE; b/err held stable in DONE until out_ready is seen at an edge.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake carrying c [D_WIDTH:0] and a [D_WIDTH-1:0]
//   out_valid / out_ready result handshake carrying b [D_WIDTH-1:0] and err
//   op_count [31:0]       completed operations, saturating
//
// Build option: define SERIAL_SUBTRACTOR_OPCOUNT_EN to get the op_count register;
// without it op_count reads as zero and no counter is built.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH:0]   c,
  input  logic [D_WIDTH-1:0] a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] b,
  output logic               err,
  output logic [31:0]        op_count
);

  localparam int NUM_CHUNKS = num_chunks(D_WIDTH, CHUNK_W);
  localparam int PAD_W      = pad_w(D_WIDTH, CHUNK_W);
  // A single-chunk build still needs a 1-bit counter so the port widths stay legal.
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  state_e             state_q;
  logic [PAD_W-1:0]   c_sh_q;
  logic [PAD_W-1:0]   a_sh_q;
  logic [PAD_W-1:0]   res_sh_q;
  logic [PAD_W-1:0]   res_nxt;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [D_WIDTH-1:0] b_q;
  logic               err_q;

  logic [CHUNK_W-1:0] diff_chunk;
  logic               borrow_out;
  logic               last_chunk;
  logic               err_nxt;

  // The low slice of each operand register is always the slice being worked on.
  chunk_sub #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_sub (
    .x    (c_sh_q[CHUNK_W-1:0]),
    .y    (a_sh_q[CHUNK_W-1:0]),
    .bin  (borrow_q),
    .d    (diff_chunk),
    .bout (borrow_out)
  );

  // Differences enter at the top and walk down, so after NUM_CHUNKS shifts the
  // first (least significant) slice sits at bit 0.
  always_comb begin
    res_nxt                     = res_sh_q >> CHUNK_W;
    res_nxt[PAD_W-1 -: CHUNK_W] = diff_chunk;
  end

  assign last_chunk = (cnt_q == LAST_CNT);

  // A final borrow means c < a; a set bit at or above D_WIDTH means the
  // difference is too wide for b. Padding bits above D_WIDTH can only be set
  // when the borrow is also set, so including them changes nothing.
  assign err_nxt = borrow_out | (|res_nxt[PAD_W-1:D_WIDTH]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      c_sh_q   <= '0;
      a_sh_q   <= '0;
      res_sh_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            c_sh_q   <= PAD_W'(c);
            a_sh_q   <= PAD_W'(a);
            res_sh_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end

        RUN: begin
          c_sh_q   <= c_sh_q >> CHUNK_W;
          a_sh_q   <= a_sh_q >> CHUNK_W;
          res_sh_q <= res_nxt;
          borrow_q <= borrow_out;
          if (last_chunk) begin
            // Latch the result on the last slice so DONE only has to hold it.
            b_q     <= res_nxt[D_WIDTH-1:0];
            err_q   <= err_nxt;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode straight from state so reset takes effect at once.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign b         = b_q;
  assign err       = err_q;

`ifdef SERIAL_SUBTRACTOR_OPCOUNT_EN
  logic [31:0] op_cnt_q;

  // Counts output handshakes; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
    end else if ((state_q == DONE) && out_ready && (op_cnt_q != 32'hFFFF_FFFF)) begin
      op_cnt_q <= op_cnt_q + 32'd1;
    end
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose: directed self-checking bench for serial_subtractor with default parameters.
// Latency: expects out_valid 5 edges after acceptance, in_ready back one edge after the output handshake.
// Backpressure: exercises out_ready stalls with in_valid held high during DONE.
module tb_serial_subtractor;

  localparam int D_WIDTH    = 32;
  localparam int CHUNK_W    = 8;
  localparam int NUM_CHUNKS = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH:0]   c;
  logic [D_WIDTH-1:0] a;
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] b;
  logic               err;
  logic [31:0]        op_count;

  int n_checks = 0;
  int n_pass   = 0;
  int ops_done = 0;

  always #5 clk = ~clk;

  serial_subtractor #(
    .D_WIDTH (D_WIDTH),
    .CHUNK_W (CHUNK_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .err       (err),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_ops();
`ifdef SERIAL_SUBTRACTOR_OPCOUNT_EN
    return 32'(ops_done);
`else
    return 32'd0;
`endif
  endfunction

  // Presents operands and waits for the accepting edge; returns #1 after it.
  task automatic send(input string tag, input logic [D_WIDTH:0] cv, input logic [D_WIDTH-1:0] av);
    logic was_rdy;
    int   waited;
    in_valid = 1'b1;
    c        = cv;
    a        = av;
    waited   = 0;
    do begin
      was_rdy = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!was_rdy && waited < 50);
    in_valid = 1'b0;
    check({tag, "_accept"}, 64'(was_rdy), 64'd1);
  endtask

  // Called #1 after the accepting edge. stall > 0 holds out_ready low that many
  // edges after out_valid while new operands are offered.
  task automatic collect(input string tag, input logic [D_WIDTH-1:0] eb, input logic eerr,
                         input int stall);
    int   lat;
    logic rdy_seen;
    lat       = 0;
    rdy_seen  = 1'b0;
    out_ready = (stall == 0);
    while (!out_valid && lat < 20) begin
      rdy_seen |= in_ready;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(NUM_CHUNKS));
    check({tag, "_rdy_busy"}, 64'(rdy_seen), 64'd0);
    check({tag, "_b"}, 64'(b), 64'(eb));
    check({tag, "_err"}, 64'(err), 64'(eerr));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      c        = 33'h99;
      a        = 32'h1;
      @(posedge clk);
      #1;
      check({tag, "_stall_vld"}, 64'(out_valid), 64'd1);
      check({tag, "_stall_b"}, 64'(b), 64'(eb));
      check({tag, "_stall_err"}, 64'(err), 64'(eerr));
      check({tag, "_stall_rdy"}, 64'(in_ready), 64'd0);
    end
    if (stall > 0) in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    ops_done++;
    check({tag, "_vld_clr"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    check({tag, "_opcnt"}, 64'(op_count), 64'(exp_ops()));
  endtask

  initial begin
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c         = '0;
    a         = '0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_b", 64'(b), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_opcnt", 64'(op_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic subtraction
    send("t1", 33'd5, 32'd2);
    collect("t1", 32'd3, 1'b0, 0);

    // Back-to-back: op2 is offered the moment op1 is accepted
    send("t2a", 33'd40, 32'd20);
    in_valid = 1'b1;
    c        = 33'h1_0000_0000;
    a        = 32'd1;
    collect("t2a", 32'd20, 1'b0, 0);
    send("t2b", 33'h1_0000_0000, 32'd1);
    collect("t2b", 32'hFFFF_FFFF, 1'b0, 0);

    // Negative result (final borrow) and overwide result
    send("t3a", 33'd2, 32'd3);
    collect("t3a", 32'hFFFF_FFFF, 1'b1, 0);
    send("t3b", 33'h1_0000_0005, 32'd3);
    collect("t3b", 32'd2, 1'b1, 0);

    // Output backpressure for 3 edges
    send("t4", 33'd15, 32'd5);
    collect("t4", 32'd10, 1'b0, 3);

    // Asynchronous reset in the middle of RUN (cnt == 2)
    send("t5", 33'd100, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    ops_done = 0;
    check("t5_rst_in_ready", 64'(in_ready), 64'd1);
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_b", 64'(b), 64'd0);
    check("t5_rst_err", 64'(err), 64'd0);
    check("t5_rst_opcnt", 64'(op_count), 64'd0);
    #2;
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("t5_no_ghost_vld", 64'(seen), 64'd0);
    send("t6", 33'd7, 32'd7);
    collect("t6", 32'd0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d of expected run", n_checks);
    $fatal(1);
  end

endmodule
